// File: rtl/axi_rd_sched_if.sv
// Link between the read scheduler and the m_axi_rd master: burst command out, beats back.
interface axi_rd_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;

  modport master (
    output rd_start, rd_addr, rd_len,
    input  rd_vld, rd_data, rd_done
  );

  modport slave (
    input  rd_start, rd_addr, rd_len,
    output rd_vld, rd_data, rd_done
  );
endinterface

// File: rtl/axi_rd_sched.sv
// Round-robin read scheduler: shares one AXI read master between NUM_REQ clients,
// splitting transfers into bursts of at most MAX_BURST beats that never cross 4 KB.
module axi_rd_sched #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0]     req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_rvld,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      busy,
  axi_rd_sched_if.master            m_rd
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BPB    = DATA_W / 8;
  localparam int BPB_SH = $clog2(BPB);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  owner, last_grant, grant_idx, idx_n;
  logic              grant_any;
  logic [ADDR_W-1:0] cur_addr, rd_addr_q, sel_addr;
  logic [15:0]       remaining, sel_len, lim;
  logic [12:0]       room_beats;
  logic [7:0]        rd_len_q, blen;

  // Round-robin search starting just above the previous owner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx_n     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_n = IDX_W'((32'(last_grant) + 1 + k) % NUM_REQ);
      if (!grant_any && req_valid[idx_n]) begin
        grant_any = 1'b1;
        grant_idx = idx_n;
      end
    end
  end

  assign sel_addr = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_len  = req_len[32'(grant_idx)*16 +: 16];

  // Burst length: limited by what is left, MAX_BURST, and beats up to the next 4 KB page.
  always_comb begin
    room_beats = (13'd4096 - {1'b0, cur_addr[11:0]}) >> BPB_SH;
    lim        = remaining;
    if (lim > 16'(MAX_BURST)) lim = 16'(MAX_BURST);
    if (lim > 16'(room_beats)) lim = 16'(room_beats);
    blen = 8'(lim);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = NEXT;
      NEXT:    state_nx = (remaining == '0) ? IDLE : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (m_rd.rd_done) state_nx = NEXT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    req_done      = '0;
    req_rvld      = '0;
    busy          = (state != IDLE);
    m_rd.rd_start = (state == ISSUE);
    m_rd.rd_addr  = rd_addr_q;
    m_rd.rd_len   = rd_len_q;
    req_rdata     = m_rd.rd_data;
    if (state == IDLE && grant_any && rst_n) req_ready = NUM_REQ'(1) << grant_idx;
    if (state == NEXT && remaining == '0)    req_done  = NUM_REQ'(1) << owner;
    if (m_rd.rd_vld && busy)                 req_rvld  = NUM_REQ'(1) << owner;
  end

  // rd_addr/rd_len are captured in NEXT and left untouched until the following NEXT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cur_addr   <= '0;
      remaining  <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          owner     <= grant_idx;
          cur_addr  <= sel_addr;
          remaining <= sel_len;
        end
        NEXT: if (remaining == '0) begin
          last_grant <= owner;
        end else begin
          rd_addr_q <= cur_addr;
          rd_len_q  <= blen;
        end
        WAIT: if (m_rd.rd_done) begin
          cur_addr  <= cur_addr + (ADDR_W'(rd_len_q) << BPB_SH);
          remaining <= remaining - 16'(rd_len_q);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_sched.sv
// Bench for axi_rd_sched: directed and random transfers against a page/burst-splitting model.
module tb_axi_rd_sched;
  localparam int NUM_REQ = 3, ADDR_W = 32, DATA_W = 32, MAX_BURST = 16, BPB = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_rvld, req_done;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*16-1:0]     req_len;
  logic [DATA_W-1:0]         req_rdata;
  logic                      busy;

  axi_rd_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_rd();

  axi_rd_sched #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .req_rvld(req_rvld), .req_rdata(req_rdata), .req_done(req_done),
    .busy(busy), .m_rd(m_rd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, model_lg;
  int glitch_req = 0, glitch_ack = 0;
  logic [31:0] c_addr[NUM_REQ];
  int          c_len[NUM_REQ];
  logic [31:0] ex_addr[$];
  int          ex_len[$];
  int          st_cyc[$], st_len[$], dn_cyc[$], rx_cli[$], dq_cyc[$];
  logic [31:0] st_addr[$], rx_dat[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  always @(negedge clk) begin
    if (m_rd.rd_start) begin
      st_cyc.push_back(cyc); st_addr.push_back(m_rd.rd_addr); st_len.push_back(int'(m_rd.rd_len));
    end
    if (m_rd.rd_vld && m_rd.rd_done && rst_n) dn_cyc.push_back(cyc);
    for (int i = 0; i < NUM_REQ; i++)
      if (req_rvld[i]) begin rx_cli.push_back(i); rx_dat.push_back(req_rdata); end
    if (|req_done) dq_cyc.push_back(cyc);
  end

  // Memory side of m_axi_rd: answers each burst with randomly spaced beats.
  initial begin
    logic [31:0] ba;
    int bl;
    m_rd.rd_vld = 1'b0; m_rd.rd_done = 1'b0; m_rd.rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && m_rd.rd_start) begin
        ba = m_rd.rd_addr; bl = int'(m_rd.rd_len);
        @(posedge clk); #1;
        for (int k = 0; k < bl && rst_n; k++) begin
          while ($urandom_range(0, 3) == 0 && rst_n) begin @(posedge clk); #1; end
          m_rd.rd_vld = 1'b1; m_rd.rd_done = (k == bl - 1);
          m_rd.rd_data = beat_data(ba + 32'(k * BPB));
          @(posedge clk); #1;
          m_rd.rd_vld = 1'b0; m_rd.rd_done = 1'b0;
        end
      end else if (glitch_req != glitch_ack) begin
        m_rd.rd_vld = 1'b1; m_rd.rd_done = 1'b1; m_rd.rd_data = '1;
        @(posedge clk); #1;
        m_rd.rd_vld = 1'b0; m_rd.rd_done = 1'b0;
        glitch_ack++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_bursts(input logic [31:0] a, input int len);
    int room, b;
    ex_addr.delete(); ex_len.delete();
    while (len > 0) begin
      room = (4096 - int'(a[11:0])) / BPB;
      b = len;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      ex_addr.push_back(a); ex_len.push_back(b);
      a = a + 32'(b * BPB);
      len = len - b;
    end
  endtask

  task automatic set_client(input int c, input logic [31:0] a, input int l);
    c_addr[c] = a; c_len[c] = l;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_len[c*16 +: 16] = 16'(l);
  endtask

  task automatic run(input logic [NUM_REQ-1:0] mask, input int n);
    int k, g, rc, dc, sb, db, rb, qb, bad, nb;
    logic b1, b2;
    req_valid = mask; #1;
    for (int t = 0; t < n; t++) begin
      g = -1;
      for (int j = 1; j <= NUM_REQ; j++) begin
        int idx = (model_lg + j) % NUM_REQ;
        if (g < 0 && mask[idx]) g = idx;
      end
      sb = st_cyc.size(); db = dn_cyc.size(); rb = rx_cli.size(); qb = dq_cyc.size();
      k = 0;
      while (req_ready == '0 && k < 100) begin @(negedge clk); #1; k++; end
      chk("accept_grant", 64'(req_ready), 64'(1) << g);
      if (req_ready == '0) begin req_valid = '0; return; end
      rc = cyc;
      model_bursts(c_addr[g], c_len[g]);
      @(posedge clk); #1;
      if (t == n - 1) begin
        req_valid = '0;
        req_addr = {$urandom, $urandom, $urandom};
        req_len = {$urandom, $urandom};
      end
      @(negedge clk); #1;
      k = 0;
      while (req_done == '0 && k < 4000) begin @(negedge clk); #1; k++; end
      chk("done_onehot", 64'(req_done), 64'(1) << g);
      dc = cyc; b1 = busy;
      @(negedge clk); #1;
      b2 = busy;
      model_lg = g;
      chk("busy_at_done", 64'(b1), 64'(1));
      chk("busy_after_done", 64'(b2), 64'(0));
      nb = st_cyc.size() - sb;
      chk("burst_count", 64'(nb), 64'(ex_addr.size()));
      chk("rd_done_count", 64'(dn_cyc.size() - db), 64'(ex_addr.size()));
      bad = 0;
      for (int i = 0; i < nb && i < ex_addr.size(); i++) begin
        if (st_addr[sb+i] !== ex_addr[i] || st_len[sb+i] != ex_len[i]) bad++;
        if (i == 0 && st_cyc[sb] != rc + 2) bad++;
        if (i > 0 && db + i - 1 < dn_cyc.size() && st_cyc[sb+i] != dn_cyc[db+i-1] + 2) bad++;
      end
      chk("burst_addr_len_timing_bad", 64'(bad), 64'(0));
      if (ex_addr.size() == 0) chk("done_cycle_zero_len", 64'(dc), 64'(rc + 1));
      else if (dn_cyc.size() > db) chk("done_cycle", 64'(dc), 64'(dn_cyc[dn_cyc.size()-1] + 1));
      chk("beat_count", 64'(rx_cli.size() - rb), 64'(c_len[g]));
      bad = 0;
      for (int i = 0; i < rx_cli.size() - rb; i++)
        if (rx_cli[rb+i] != g || rx_dat[rb+i] !== beat_data(c_addr[g] + 32'(i * BPB))) bad++;
      chk("beat_owner_data_bad", 64'(bad), 64'(0));
      chk("done_pulses", 64'(dq_cyc.size() - qb), 64'(1));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [NUM_REQ-1:0] mask;
    int k, sb, qb, base;
    req_valid = '0; req_addr = '0; req_len = '0;
    model_lg = NUM_REQ - 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({busy, m_rd.rd_start, m_rd.rd_addr, m_rd.rd_len, req_ready, req_rvld, req_done}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk); #1;

    set_client(0, 32'h0000_1000, 8);  run(3'b001, 1);
    set_client(0, 32'h0000_2000, 40); run(3'b001, 1);
    set_client(1, 32'h0000_0FF0, 8);  run(3'b010, 1);
    set_client(2, 32'hFFFF_FFF0, 8);  run(3'b100, 1);
    set_client(1, 32'h0000_3000, 0);  run(3'b010, 1);
    set_client(0, 32'h0000_4000, 5);
    set_client(1, 32'h0000_5FF8, 6);  run(3'b011, 4);

    base = st_cyc.size() + dq_cyc.size() + rx_cli.size();
    glitch_req++;
    repeat (4) @(negedge clk);
    #1;
    chk("glitch_idle_state", 64'({busy, req_done, req_rvld}), 64'(0));
    chk("glitch_no_activity", 64'(st_cyc.size() + dq_cyc.size() + rx_cli.size() - base), 64'(0));

    set_client(0, 32'h0000_2000, 40);
    sb = st_cyc.size();
    req_valid = 3'b001; #1;
    k = 0;
    while (req_ready == '0 && k < 100) begin @(negedge clk); #1; k++; end
    chk("rst_mid_accept", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    k = 0;
    while (st_cyc.size() == sb && k < 100) begin @(negedge clk); #1; k++; end
    repeat (3) @(negedge clk);
    #1;
    qb = dq_cyc.size();
    rst_n = 1'b0; #1;
    chk("reset_mid_outputs", 64'({busy, m_rd.rd_start, m_rd.rd_addr, m_rd.rd_len, req_ready, req_rvld, req_done}), 64'(0));
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_lg = NUM_REQ - 1;
    repeat (3) @(negedge clk);
    #1;
    chk("no_done_after_reset", 64'(dq_cyc.size() - qb), 64'(0));
    set_client(1, 32'h0000_1000, 8);  run(3'b010, 1);

    repeat (25) begin
      mask = 3'($urandom_range(1, 7));
      for (int c = 0; c < NUM_REQ; c++) if (mask[c]) begin
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 15) * 4);
        set_client(c, a, $urandom_range(0, 40));
      end
      run(mask, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_sched.md
# axi_rd_sched

Read scheduler in front of the `m_axi_rd` master. It shares the single AXI read channel between `NUM_REQ` client requesters using round-robin arbitration. It splits each accepted transfer into AXI bursts of at most `MAX_BURST` beats that never cross a 4 KB boundary, and routes the returning beats back to the owning client. It sits between the DMA/video clients and `m_axi_rd`, and owns that master's `rd_start`/`rd_addr`/`rd_len` inputs.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..4.
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: beat width, power of two ≥ 32. `BPB = DATA_W/8` bytes per beat.
- `MAX_BURST`, 16: maximum beats per burst, 1..128.

Ports (clock and reset are `clk` and `rst_n`; one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-client request; held high until the matching `req_ready` bit.
- `req_addr`  in  NUM_REQ*ADDR_W  per-client start byte address, beat-aligned.
- `req_len`  in  NUM_REQ*16  per-client total beats; 0 is legal.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse, one-hot.
- `req_rvld`  out  NUM_REQ  per-client read-data valid.
- `req_rdata`  out  DATA_W  shared read data.
- `req_done`  out  NUM_REQ  one-cycle pulse: transfer complete.
- `busy`  out  1  high while a transfer is owned.
- `rd_start`  out  1  one-cycle burst start to `m_axi_rd`.
- `rd_addr`  out  ADDR_W  burst start address.
- `rd_len`  out  8  burst beats, 1..MAX_BURST.
- `rd_vld`  in  1  beat valid from `m_axi_rd`.
- `rd_data`  in  DATA_W  beat data.
- `rd_done`  in  1  last beat of the burst; coincides with the final `rd_vld`.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `NEXT`.
- `IDLE`: if any `req_valid` bit is set, grant the first set bit searching upward from `(last_grant+1) mod NUM_REQ`. Pulse that `req_ready` bit and latch `cur_addr`, `remaining = req_len` and `owner`. Go to `NEXT`.
- `NEXT`:
  - If `remaining==0`, pulse `req_done[owner]`, update `last_grant=owner` and go to `IDLE`.
  - Otherwise compute `blen = min(remaining, MAX_BURST, (4096 - cur_addr[11:0])/BPB)`, register `rd_addr=cur_addr` and `rd_len=blen`, and go to `ISSUE`.
- `ISSUE`: `rd_start=1` for exactly one cycle, then go to `WAIT`.
- `WAIT`: on `rd_done`, set `cur_addr += blen*BPB` and `remaining -= blen`, then go to `NEXT`.
- `rd_addr` and `rd_len` hold stable from `ISSUE` through the `rd_done` cycle, because `m_axi_rd` derives `arlen` combinationally from `rd_len`.
- Data routing is combinational:
  - `req_rvld[i] = rd_vld & busy & (owner==i)`.
  - `req_rdata = rd_data`.
- `rd_vld` or `rd_done` seen outside `WAIT` is ignored.
- A grant is held for the whole transfer; there is no preemption.
- `req_len=0`: the request is accepted, no burst is issued, and `req_done` pulses.
- Arithmetic:
  - `remaining` is 16 bits, `cur_addr` is ADDR_W bits, and the blen computation is 13 bits.
  - `cur_addr` wraps modulo 2^ADDR_W.
- Client inputs are sampled only in the accept cycle.

## Timing
- Reset values:
  - Outputs `req_ready`, `req_rvld`, `req_done`, `busy`, `rd_start`, `rd_addr` and `rd_len` are all 0.
  - State `IDLE`.
  - `last_grant = NUM_REQ-1`, so client 0 has first priority.
- Accept at cycle T (`req_ready` high). `NEXT` at T+1. `rd_start` at T+2.
- `rd_done` at cycle D: `NEXT` at D+1, and either the next `rd_start` at D+2 or `req_done` at D+1.
- `req_done` is registered; it is high during the `NEXT` cycle in which `busy` is still 1. `busy` drops the following cycle.
- Minimum gap from `req_done` to the next `req_ready` is 1 cycle (the `IDLE` cycle).
- Dropping `req_valid` without a `req_ready` withdraws the request with no side effect.
- Reset asserted mid-transfer returns everything to reset values immediately; the partial transfer is abandoned and no `req_done` is produced.

## Test plan
- Single transfer: client 0, addr 0x1000, len 8. Expect one `rd_start` with `rd_addr=0x1000` and `rd_len=8`, 8 `req_rvld[0]` pulses carrying data in order, and `req_done[0]` at D+1.
- Split: addr 0x2000, len 40, MAX_BURST 16, DATA_W 32. Expect bursts (0x2000,16), (0x2040,16), (0x2080,8), then `req_done`.
- 4 KB crossing: addr 0x0FF0, len 8, DATA_W 32. Expect bursts (0x0FF0,4) and (0x1000,4).
- Arbitration: clients 0 and 1 assert together and reassert immediately. Expect grants in order 0, 1, 0, 1, with no `req_rvld` on the non-owner.
- Zero length: client 1, len 0. Expect `req_ready[1]`, no `rd_start`, and `req_done[1]` one cycle later.
- Reset mid-burst: assert `rst_n=0` during `WAIT`. Expect all outputs 0 and state `IDLE` in the same cycle, and no `req_done`. The next request then proceeds normally.
